forward_decider: RTL and testbench

Parametrised forwarding-decision stage between the ingress frame parser and the per-port egress queues. For each accepted frame it issues a destination lookup to the address table and tracks outstanding lookups in order. It turns each result into a unicast, flood or drop decision, and holds per-port write requests until each targeted egress queue acknowledges. Unlike the previous translator, it excludes the ingress port from floods, filters same-port unicasts, supports a variable-latency table, and applies backpressure.

---
 rtl/forward_decider.sv | 207 ++++++++++++++++++++
 tb/tb_forward_decider.sv | 295 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/forward_decider.sv
// forward_decider: turns address-table lookups into unicast, flood or
// drop decisions and holds per-port write requests until acknowledged.
package switch_pkg;
    localparam int NUM_PORTS = 4;
endpackage

package mem_pkg;
    localparam int ADDR_W = 16;
endpackage

module forward_decider #(
    parameter int NUM_PORTS = switch_pkg::NUM_PORTS,
    parameter int ADDR_W    = mem_pkg::ADDR_W,
    parameter int DEPTH     = 4,
    localparam int PORT_W   = $clog2(NUM_PORTS)
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        input_valid_i,
    output logic                        input_ready_o,
    input  logic [ADDR_W-1:0]           start_ptr_i,
    input  logic [47:0]                 dest_addr_i,
    input  logic [PORT_W-1:0]           src_port_i,
    output logic                        lookup_req_o,
    output logic [47:0]                 lookup_addr_o,
    input  logic                        lookup_valid_i,
    input  logic                        lookup_hit_i,
    input  logic [PORT_W-1:0]           lookup_port_i,
    output logic [NUM_PORTS-1:0]        write_reqs_o,
    output logic [ADDR_W*NUM_PORTS-1:0] start_ptrs_o,
    input  logic [NUM_PORTS-1:0]        write_ack_i,
    output logic                        drop_o,
    output logic [ADDR_W-1:0]           drop_ptr_o
);

    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);

    // Pending-frame FIFO: one entry per accepted, undecided frame.
    logic [ADDR_W-1:0] r_pf_ptr [DEPTH];
    logic [PORT_W-1:0] r_pf_src [DEPTH];
    logic              r_pf_bc  [DEPTH];
    logic [IDX_W-1:0]  r_pf_wr;
    logic [IDX_W-1:0]  r_pf_rd;
    logic [CNT_W-1:0]  r_count;

    // Response FIFO: table results waiting for the output stage.
    logic              r_rf_hit  [DEPTH];
    logic [PORT_W-1:0] r_rf_port [DEPTH];
    logic [IDX_W-1:0]  r_rf_wr;
    logic [IDX_W-1:0]  r_rf_rd;
    logic [CNT_W-1:0]  r_rcount;

    logic                              r_lk_req;
    logic [47:0]                       r_lk_addr;
    logic [NUM_PORTS-1:0]              r_wreq;
    logic [NUM_PORTS-1:0][ADDR_W-1:0]  r_sptr;
    logic                              r_drop;
    logic [ADDR_W-1:0]                 r_drop_ptr;

    logic                 w_accept;
    logic                 w_rf_empty;
    logic                 w_rsp_avail;
    logic                 w_free;
    logic                 w_decide;
    logic                 w_load;
    logic                 w_filter;
    logic                 w_rf_push;
    logic                 w_rf_pop;
    logic [ADDR_W-1:0]    w_h_ptr;
    logic [PORT_W-1:0]    w_h_src;
    logic                 w_h_bc;
    logic                 w_h_hit;
    logic [PORT_W-1:0]    w_h_port;
    logic                 w_port_bad;
    logic                 w_flood;
    logic [NUM_PORTS-1:0] w_src_oh;
    logic [NUM_PORTS-1:0] w_dst_oh;
    logic [NUM_PORTS-1:0] w_mask;

    function automatic logic [IDX_W-1:0] next_idx(input logic [IDX_W-1:0] i);
        if (i == IDX_W'(DEPTH - 1)) return '0;
        return i + IDX_W'(1);
    endfunction

    assign input_ready_o = (r_count < CNT_W'(DEPTH));
    assign w_accept      = input_valid_i & input_ready_o;

    // An empty response FIFO is bypassed so a result can decide in
    // the cycle it arrives.
    assign w_rf_empty  = (r_rcount == '0);
    assign w_rsp_avail = ~w_rf_empty | lookup_valid_i;
    assign w_h_hit     = w_rf_empty ? lookup_hit_i  : r_rf_hit[r_rf_rd];
    assign w_h_port    = w_rf_empty ? lookup_port_i : r_rf_port[r_rf_rd];
    assign w_h_ptr     = r_pf_ptr[r_pf_rd];
    assign w_h_src     = r_pf_src[r_pf_rd];
    assign w_h_bc      = r_pf_bc[r_pf_rd];

    assign w_free   = ~|(r_wreq & ~write_ack_i);
    assign w_decide = (r_count != '0) & w_rsp_avail & w_free;
    assign w_rf_push = lookup_valid_i & ~(w_decide & w_rf_empty);
    assign w_rf_pop  = w_decide & ~w_rf_empty;

    assign w_port_bad = (32'(w_h_port) >= 32'(NUM_PORTS));
    assign w_flood    = w_h_bc | ~w_h_hit | w_port_bad;
    assign w_src_oh   = NUM_PORTS'(1) << w_h_src;
    assign w_dst_oh   = NUM_PORTS'(1) << w_h_port;

    // Flood skips the ingress port; a hit back to the ingress port
    // produces an empty mask, which means the frame is filtered.
    always_comb begin
        w_mask = '0;
        if (w_flood)
            w_mask = ~w_src_oh;
        else if (w_h_port != w_h_src)
            w_mask = w_dst_oh;
    end

    assign w_load   = w_decide & (|w_mask);
    assign w_filter = w_decide & ~(|w_mask);

    // FIFO pointers and occupancy counts.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pf_wr  <= '0;
            r_pf_rd  <= '0;
            r_count  <= '0;
            r_rf_wr  <= '0;
            r_rf_rd  <= '0;
            r_rcount <= '0;
        end else begin
            if (w_accept) r_pf_wr <= next_idx(r_pf_wr);
            if (w_decide) r_pf_rd <= next_idx(r_pf_rd);
            if (w_accept && !w_decide)
                r_count <= r_count + CNT_W'(1);
            else if (!w_accept && w_decide)
                r_count <= r_count - CNT_W'(1);
            if (w_rf_push) r_rf_wr <= next_idx(r_rf_wr);
            if (w_rf_pop)  r_rf_rd <= next_idx(r_rf_rd);
            if (w_rf_push && !w_rf_pop)
                r_rcount <= r_rcount + CNT_W'(1);
            else if (!w_rf_push && w_rf_pop)
                r_rcount <= r_rcount - CNT_W'(1);
        end
    end

    // FIFO storage; entries are only read while the counts say valid.
    always_ff @(posedge clk) begin
        if (w_accept) begin
            r_pf_ptr[r_pf_wr] <= start_ptr_i;
            r_pf_src[r_pf_wr] <= src_port_i;
            r_pf_bc[r_pf_wr]  <= dest_addr_i[40];
        end
        if (w_rf_push) begin
            r_rf_hit[r_rf_wr]  <= lookup_hit_i;
            r_rf_port[r_rf_wr] <= lookup_port_i;
        end
    end

    // Issue one lookup the cycle after each accepted descriptor.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_lk_req  <= 1'b0;
            r_lk_addr <= '0;
        end else begin
            r_lk_req <= w_accept;
            if (w_accept) r_lk_addr <= dest_addr_i;
        end
    end

    // Per-port requests: clear on ack, reload when a decision lands.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wreq <= '0;
            r_sptr <= '0;
        end else begin
            if (w_load) r_wreq <= w_mask;
            else        r_wreq <= r_wreq & ~write_ack_i;
            for (int p = 0; p < NUM_PORTS; p++) begin
                if (w_load && w_mask[p]) r_sptr[p] <= w_h_ptr;
            end
        end
    end

    // One-cycle drop pulse for filtered frames.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_drop     <= 1'b0;
            r_drop_ptr <= '0;
        end else begin
            r_drop <= w_filter;
            if (w_filter) r_drop_ptr <= w_h_ptr;
        end
    end

    // A response with no lookup outstanding breaks the table protocol.
    assert property (@(posedge clk) disable iff (!rst_n)
        lookup_valid_i |-> (r_count > r_rcount));

    assign lookup_req_o  = r_lk_req;
    assign lookup_addr_o = r_lk_addr;
    assign write_reqs_o  = r_wreq;
    assign start_ptrs_o  = r_sptr;
    assign drop_o        = r_drop;
    assign drop_ptr_o    = r_drop_ptr;

endmodule

// File: tb/tb_forward_decider.sv
// tb_forward_decider: directed frames with a scoreboard of expected
// decisions and lookups, popped by an independent output monitor.
module tb_forward_decider;
    localparam int NP = 4;
    localparam int AW = 16;
    localparam int DP = 4;
    localparam int PW = 2;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              input_valid_i = 1'b0;
    logic              input_ready_o;
    logic [AW-1:0]     start_ptr_i = '0;
    logic [47:0]       dest_addr_i = '0;
    logic [PW-1:0]     src_port_i = '0;
    logic              lookup_req_o;
    logic [47:0]       lookup_addr_o;
    logic              lookup_valid_i = 1'b0;
    logic              lookup_hit_i = 1'b0;
    logic [PW-1:0]     lookup_port_i = '0;
    logic [NP-1:0]     write_reqs_o;
    logic [AW*NP-1:0]  start_ptrs_o;
    logic [NP-1:0]     write_ack_i = '0;
    logic              drop_o;
    logic [AW-1:0]     drop_ptr_o;

    always #5 clk = ~clk;

    forward_decider #(.NUM_PORTS(NP), .ADDR_W(AW), .DEPTH(DP)) dut (
        .clk(clk), .rst_n(rst_n),
        .input_valid_i(input_valid_i), .input_ready_o(input_ready_o),
        .start_ptr_i(start_ptr_i), .dest_addr_i(dest_addr_i),
        .src_port_i(src_port_i),
        .lookup_req_o(lookup_req_o), .lookup_addr_o(lookup_addr_o),
        .lookup_valid_i(lookup_valid_i), .lookup_hit_i(lookup_hit_i),
        .lookup_port_i(lookup_port_i),
        .write_reqs_o(write_reqs_o), .start_ptrs_o(start_ptrs_o),
        .write_ack_i(write_ack_i),
        .drop_o(drop_o), .drop_ptr_o(drop_ptr_o)
    );

    typedef struct {
        bit            drop;
        logic [NP-1:0] mask;
        logic [AW-1:0] ptr;
    } exp_t;

    exp_t        exp_q[$];
    logic [47:0] lk_q[$];
    int          checks = 0;
    int          errors = 0;
    logic [NP-1:0] prev_wreq = '0;
    logic [NP-1:0] prev_ack = '0;

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    // Monitor: a load is any change not explained by the acks applied.
    always @(negedge clk) begin : mon
        logic [NP-1:0] hold;
        exp_t          e;
        bit            ok;
        logic [47:0]   la;
        if (!rst_n) begin
            prev_wreq = '0;
            prev_ack  = '0;
        end else begin
            hold = prev_wreq & ~prev_ack;
            if (write_reqs_o !== hold) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_load", 64'(write_reqs_o), 64'(hold));
                end else begin
                    e  = exp_q.pop_front();
                    ok = !e.drop && (write_reqs_o === e.mask);
                    for (int p = 0; p < NP; p++)
                        if (e.mask[p] && start_ptrs_o[p*AW +: AW] !== e.ptr)
                            ok = 1'b0;
                    checks++;
                    if (!ok) begin
                        errors++;
                        $display("FAIL load: got mask=%b ptrs=%h expected drop=%0d mask=%b ptr=%h",
                                 write_reqs_o, start_ptrs_o, e.drop, e.mask, e.ptr);
                    end
                end
            end
            if (drop_o) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_drop", 64'(drop_o), 64'(0));
                end else begin
                    e  = exp_q.pop_front();
                    ok = e.drop && (drop_ptr_o === e.ptr);
                    checks++;
                    if (!ok) begin
                        errors++;
                        $display("FAIL drop: got ptr=%h expected drop=%0d mask=%b ptr=%h",
                                 drop_ptr_o, e.drop, e.mask, e.ptr);
                    end
                end
            end
            if (lookup_req_o) begin
                if (lk_q.size() == 0) begin
                    chk("unexpected_lookup", 64'(lookup_req_o), 64'(0));
                end else begin
                    la = lk_q.pop_front();
                    chk("lookup_addr", 64'(lookup_addr_o), 64'(la));
                end
            end
            prev_wreq = write_reqs_o;
            prev_ack  = write_ack_i;
        end
    end

    task automatic send(input logic [PW-1:0] src, input logic [47:0] da,
                        input logic [AW-1:0] ptr, input bit drp,
                        input logic [NP-1:0] mask);
        exp_t e;
        bit   acc = 1'b0;
        e.drop = drp;
        e.mask = mask;
        e.ptr  = ptr;
        exp_q.push_back(e);
        lk_q.push_back(da);
        input_valid_i = 1'b1;
        src_port_i    = src;
        dest_addr_i   = da;
        start_ptr_i   = ptr;
        for (int i = 0; i < 40 && !acc; i++) begin
            acc = input_ready_o;
            cycle();
        end
        input_valid_i = 1'b0;
        if (!acc) chk("accept_timeout", 64'(acc), 64'(1));
    endtask

    task automatic respond(input bit hit, input logic [PW-1:0] port);
        lookup_valid_i = 1'b1;
        lookup_hit_i   = hit;
        lookup_port_i  = port;
        cycle();
        lookup_valid_i = 1'b0;
    endtask

    task automatic do_ack(input logic [NP-1:0] m);
        bit seen = 1'b0;
        for (int i = 0; i < 40 && !seen; i++) begin
            if ((write_reqs_o & m) == m) seen = 1'b1;
            else cycle();
        end
        chk("ack_wait_req", 64'(seen), 64'(1));
        write_ack_i = m;
        cycle();
        write_ack_i = '0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        cycle();
        cycle();
        chk("rst_ready", 64'(input_ready_o), 64'(1));
        chk("rst_wreq", 64'(write_reqs_o), 64'(0));
        chk("rst_sptrs", 64'(start_ptrs_o), 64'(0));
        chk("rst_lkreq", 64'(lookup_req_o), 64'(0));
        chk("rst_lkaddr", 64'(lookup_addr_o), 64'(0));
        chk("rst_drop", 64'(drop_o), 64'(0));
        chk("rst_dropptr", 64'(drop_ptr_o), 64'(0));
        rst_n = 1'b1;
        cycle();
        chk("ready_after_rst", 64'(input_ready_o), 64'(1));

        // Unicast: hit port 2 two cycles after the request.
        send(0, 48'h0011_2233_4455, 16'h0010, 0, 4'b0100);
        cycle();
        cycle();
        respond(1, 2);
        chk("uni_wreq_r1", 64'(write_reqs_o), 64'(4'b0100));
        chk("uni_ptr2", 64'(start_ptrs_o[2*AW +: AW]), 64'(16'h0010));
        do_ack(4'b0100);
        chk("uni_cleared", 64'(write_reqs_o), 64'(0));

        // Miss flood, then a queued unicast loading on the last ack.
        send(1, 48'h0000_0000_0A01, 16'h0020, 0, 4'b1101);
        send(0, 48'h0000_0000_0A02, 16'h0021, 0, 4'b1000);
        respond(0, 0);
        respond(1, 3);
        chk("flood_wreq", 64'(write_reqs_o), 64'(4'b1101));
        do_ack(4'b1000);
        chk("flood_ack3", 64'(write_reqs_o), 64'(4'b0101));
        do_ack(4'b0001);
        chk("flood_ack0", 64'(write_reqs_o), 64'(4'b0100));
        do_ack(4'b0100);
        chk("b2b_load", 64'(write_reqs_o), 64'(4'b1000));
        do_ack(4'b1000);
        chk("b2b_cleared", 64'(write_reqs_o), 64'(0));

        // Broadcast ignores the table hit.
        send(3, 48'hFFFF_FFFF_FFFF, 16'h0030, 0, 4'b0111);
        cycle();
        respond(1, 1);
        chk("bcast_wreq", 64'(write_reqs_o), 64'(4'b0111));
        do_ack(4'b0111);
        chk("bcast_cleared", 64'(write_reqs_o), 64'(0));

        // Same-port hit is filtered.
        send(2, 48'h0002_0000_0001, 16'h003A, 1, 4'b0000);
        cycle();
        respond(1, 2);
        chk("filt_drop", 64'(drop_o), 64'(1));
        chk("filt_ptr", 64'(drop_ptr_o), 64'(16'h003A));
        chk("filt_wreq", 64'(write_reqs_o), 64'(0));
        cycle();
        chk("filt_pulse_end", 64'(drop_o), 64'(0));

        // Backpressure: four fill the stage, the fifth waits.
        send(0, 48'h0000_0000_0B01, 16'h0040, 1, 4'b0000);
        send(1, 48'h0000_0000_0B02, 16'h0041, 0, 4'b0100);
        send(2, 48'h0000_0000_0B03, 16'h0042, 1, 4'b0000);
        send(3, 48'h0000_0000_0B04, 16'h0043, 0, 4'b0111);
        chk("full_ready", 64'(input_ready_o), 64'(0));
        fork
            send(0, 48'h0000_0000_0B05, 16'h0044, 0, 4'b0010);
            begin
                cycle();
                cycle();
                chk("full_hold", 64'(input_ready_o), 64'(0));
                cycle();
                respond(1, 0);
                respond(1, 2);
                respond(1, 2);
                respond(0, 0);
            end
        join
        cycle();
        respond(1, 1);
        do_ack(4'b0100);
        do_ack(4'b0111);
        do_ack(4'b0010);
        cycle();
        cycle();
        chk("bp_exp_drained", 64'(exp_q.size()), 64'(0));
        chk("bp_lk_drained", 64'(lk_q.size()), 64'(0));

        // Reset with a live request and two frames pending.
        send(2, 48'h0000_0000_0C01, 16'h0050, 0, 4'b1011);
        cycle();
        respond(0, 0);
        send(0, 48'h0000_0000_0C02, 16'h0051, 0, 4'b1000);
        send(1, 48'h0000_0000_0C03, 16'h0052, 0, 4'b0001);
        cycle();
        cycle();
        chk("pre_rst_wreq", 64'(write_reqs_o), 64'(4'b1011));
        #2;
        rst_n = 1'b0;
        exp_q.delete();
        lk_q.delete();
        #1;
        chk("arst_wreq", 64'(write_reqs_o), 64'(0));
        chk("arst_sptrs", 64'(start_ptrs_o), 64'(0));
        chk("arst_ready", 64'(input_ready_o), 64'(1));
        chk("arst_lkaddr", 64'(lookup_addr_o), 64'(0));
        cycle();
        cycle();
        rst_n = 1'b1;
        for (int i = 0; i < 8; i++) cycle();
        chk("post_rst_ready", 64'(input_ready_o), 64'(1));

        // Fresh frame after reset must use fresh FIFO state.
        send(1, 48'h0000_0000_0D04, 16'h0060, 0, 4'b1000);
        cycle();
        respond(1, 3);
        chk("post_rst_uni", 64'(write_reqs_o), 64'(4'b1000));
        do_ack(4'b1000);
        cycle();
        chk("end_exp_empty", 64'(exp_q.size()), 64'(0));
        chk("end_lk_empty", 64'(lk_q.size()), 64'(0));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
